// File: rtl/rx_pixel_deframer_pkg.sv
// Shared definitions for the pixel UART receive path: character framing sizes
// and the receive FSM state encoding.
package rx_pixel_deframer_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;
  localparam int NUM_BYTES          = 3;
  localparam int PIXEL_W            = DATA_BITS * NUM_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/rx_pixel_deframer_sampler.sv
// Serial-line front end: two-flop synchroniser on data_rx plus the oversampling
// tick counter that yields mid-start-bit and full-bit sample strobes.
module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic data_rx,
  input  logic tick_clr,
  output logic rx_s,
  output logic mid_strobe,
  output logic bit_strobe
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic              rx_meta;
  logic [TICK_W-1:0] tick;

  // NOTE: every register here is updated with <= so all flops sample the
  // values from before the clock edge; = would chain rx_meta into rx_s in one cycle.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      tick    <= '0;
    end else begin
      rx_meta <= data_rx;
      rx_s    <= rx_meta;
      if (tick_clr || bit_strobe) tick <= '0;
      else                        tick <= tick + 1'b1;
    end
  end

  assign mid_strobe = (tick == TICK_MID);
  assign bit_strobe = (tick == TICK_LAST);

endmodule

// File: rtl/rx_pixel_deframer.sv
// Receives three UART characters (start, 8 data bits MSB-first, stop) and
// presents them as one 24-bit pixel with a single-cycle valid pulse.
module rx_pixel_deframer
  import rx_pixel_deframer_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic               baud_clk,
  input  logic               rst,
  input  logic               data_rx,
  output logic [PIXEL_W-1:0] data_out,
  output logic               valid,
  output logic               active_flag,
  output logic               done_flag,
  output logic               frame_err
);

  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int BYTE_W = $clog2(NUM_BYTES);
  localparam int HOLD_W = PIXEL_W - DATA_BITS;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  rx_state_t             state;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic                  armed;
  logic [DATA_BITS-1:0]  shift_reg;
  logic [HOLD_W-1:0]     pix_hold;
  logic                  rx_s;
  logic                  mid_strobe;
  logic                  bit_strobe;
  logic                  tick_clr;

  // Tick counter restarts on entering START and again at the mid-start sample.
  assign tick_clr = (state == ST_IDLE) || ((state == ST_START) && mid_strobe);

  rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .data_rx    (data_rx),
    .tick_clr   (tick_clr),
    .rx_s       (rx_s),
    .mid_strobe (mid_strobe),
    .bit_strobe (bit_strobe)
  );

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      armed       <= 1'b0;
      shift_reg   <= '0;
      pix_hold    <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      active_flag <= 1'b0;
      done_flag   <= 1'b1;
      frame_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the
      // branch that produces them, so they can never stick high.
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) state <= ST_START;
        end
        ST_START: begin
          if (mid_strobe) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              if (byte_cnt == '0) begin
                active_flag <= 1'b1;
                done_flag   <= 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (bit_strobe) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], rx_s};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bit_strobe) begin
            state <= ST_IDLE;
            if (rx_s) begin
              armed <= 1'b1;
              if (byte_cnt == BYTE_LAST) begin
                data_out    <= {pix_hold, shift_reg};
                valid       <= 1'b1;
                byte_cnt    <= '0;
                pix_hold    <= '0;
                active_flag <= 1'b0;
                done_flag   <= 1'b1;
              end else begin
                // Earlier bytes shift up so byte 0 ends in the top slot.
                pix_hold <= (pix_hold << DATA_BITS) | HOLD_W'(shift_reg);
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              frame_err   <= 1'b1;
              byte_cnt    <= '0;
              pix_hold    <= '0;
              armed       <= 1'b0;
              active_flag <= 1'b0;
              done_flag   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pixel_deframer.sv
// Directed bench for rx_pixel_deframer: table of whole pixels plus hand-written
// glitch, framing-error and mid-pixel reset sequences.
module tb_rx_pixel_deframer;

  logic        baud_clk = 1'b0;
  logic        rst;
  logic        data_rx;
  logic [23:0] data_out;
  logic        valid;
  logic        active_flag;
  logic        done_flag;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [23:0] got_q[$];
  int err_cnt   = 0;
  int both_cnt  = 0;
  int flag_bad  = 0;
  int act_cnt   = 0;

  always #5 baud_clk = ~baud_clk;

  rx_pixel_deframer #(.OVERSAMPLE(16)) dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .data_rx     (data_rx),
    .data_out    (data_out),
    .valid       (valid),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .frame_err   (frame_err)
  );

  always @(negedge baud_clk) begin
    if (rst === 1'b0) begin
      if (valid)                      got_q.push_back(data_out);
      if (frame_err)                  err_cnt++;
      if (valid && frame_err)         both_cnt++;
      if (active_flag)                act_cnt++;
      if (done_flag !== ~active_flag) flag_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  // One character: start bit, 8 data bits MSB first, stop bit of the given level.
  task automatic send_byte(input logic [7:0] b, input int bit_t, input logic stop);
    data_rx = 1'b0;
    #(bit_t);
    for (int i = 7; i >= 0; i--) begin
      data_rx = b[i];
      #(bit_t);
    end
    data_rx = stop;
    #(bit_t);
    data_rx = 1'b1;
  endtask

  task automatic send_pixel(input logic [23:0] p, input int gap, input int bit_t);
    @(negedge baud_clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      send_byte(p[23-8*k -: 8], bit_t, 1'b1);
      if (gap > 0 && k < 2) #(gap * 10);
    end
  endtask

  typedef struct {
    logic [23:0] pixel;
    int          gap;
    int          bit_t;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0, e0, a0;

    vecs[0] = '{pixel: 24'hA5C33C, gap: 0,  bit_t: 160, exp: 24'hA5C33C};
    vecs[1] = '{pixel: 24'h010203, gap: 37, bit_t: 160, exp: 24'h010203};
    vecs[2] = '{pixel: 24'h7F80FF, gap: 37, bit_t: 160, exp: 24'h7F80FF};
    vecs[3] = '{pixel: 24'h000000, gap: 37, bit_t: 160, exp: 24'h000000};
    vecs[4] = '{pixel: 24'hDEADBE, gap: 0,  bit_t: 165, exp: 24'hDEADBE};
    vecs[5] = '{pixel: 24'hDEADBE, gap: 0,  bit_t: 155, exp: 24'hDEADBE};
    vecs[6] = '{pixel: 24'hFFFFFF, gap: 3,  bit_t: 160, exp: 24'hFFFFFF};

    data_rx = 1'b1;
    rst     = 1'b1;
    wait_cycles(3);
    check("reset data_out",    32'(data_out), 32'h0);
    check("reset valid",       32'(valid), 32'h0);
    check("reset active_flag", 32'(active_flag), 32'h0);
    check("reset done_flag",   32'(done_flag), 32'h1);
    check("reset frame_err",   32'(frame_err), 32'h0);
    rst = 1'b0;
    wait_cycles(20);

    // Short low glitch must be rejected at the mid-start sample.
    n0 = got_q.size(); e0 = err_cnt; a0 = act_cnt;
    @(negedge baud_clk);
    #2;
    data_rx = 1'b0;
    #50;
    data_rx = 1'b1;
    wait_cycles(40);
    check("glitch active cycles", 32'(act_cnt - a0), 32'h0);
    check("glitch valid count",   32'(got_q.size() - n0), 32'h0);
    check("glitch frame_err",     32'(err_cnt - e0), 32'h0);

    for (int i = 0; i < 7; i++) begin
      n0 = got_q.size(); e0 = err_cnt;
      send_pixel(vecs[i].pixel, vecs[i].gap, vecs[i].bit_t);
      wait_cycles(4);
      check($sformatf("vec%0d valid count", i), 32'(got_q.size() - n0), 32'h1);
      check($sformatf("vec%0d data_out", i),    32'(data_out), 32'(vecs[i].exp));
      check($sformatf("vec%0d frame_err", i),   32'(err_cnt - e0), 32'h0);
      check($sformatf("vec%0d active_flag", i), 32'(active_flag), 32'h0);
      check($sformatf("vec%0d done_flag", i),   32'(done_flag), 32'h1);
      wait_cycles(10);
    end

    // Bad stop bit on byte 1 discards the pixel; next pixel is clean.
    n0 = got_q.size(); e0 = err_cnt;
    @(negedge baud_clk);
    #2;
    send_byte(8'hAA, 160, 1'b1);
    wait_cycles(2);
    check("ferr mid active_flag", 32'(active_flag), 32'h1);
    check("ferr mid done_flag",   32'(done_flag), 32'h0);
    #2;
    send_byte(8'hBB, 160, 1'b0);
    wait_cycles(6);
    check("ferr pulse count",  32'(err_cnt - e0), 32'h1);
    check("ferr active_flag",  32'(active_flag), 32'h0);
    check("ferr done_flag",    32'(done_flag), 32'h1);
    check("ferr valid count",  32'(got_q.size() - n0), 32'h0);
    wait_cycles(10);
    send_pixel(24'h123456, 0, 160);
    wait_cycles(4);
    check("after ferr valid count", 32'(got_q.size() - n0), 32'h1);
    check("after ferr data_out",    32'(data_out), 32'h123456);
    check("after ferr no new err",  32'(err_cnt - e0), 32'h1);

    // Reset during byte 2 of 0xFFFFFF drops the partial pixel.
    wait_cycles(10);
    n0 = got_q.size(); e0 = err_cnt;
    @(negedge baud_clk);
    #2;
    send_byte(8'hFF, 160, 1'b1);
    send_byte(8'hFF, 160, 1'b1);
    data_rx = 1'b0;
    #160;
    data_rx = 1'b1;
    #480;
    @(negedge baud_clk);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
    check("rst mid data_out",    32'(data_out), 32'h0);
    check("rst mid active_flag", 32'(active_flag), 32'h0);
    check("rst mid done_flag",   32'(done_flag), 32'h1);
    wait_cycles(200);
    check("rst mid valid count", 32'(got_q.size() - n0), 32'h0);
    check("rst mid frame_err",   32'(err_cnt - e0), 32'h0);
    send_pixel(24'h000001, 0, 160);
    wait_cycles(4);
    check("after rst valid count", 32'(got_q.size() - n0), 32'h1);
    check("after rst data_out",    32'(data_out), 32'h000001);

    wait_cycles(20);
    check("valid and frame_err overlap", 32'(both_cnt), 32'h0);
    check("done_flag tracks ~active",    32'(flag_bad), 32'h0);
    check("total valid count",           32'(got_q.size()), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
